// File: rtl/prog_seq_pkg.sv
// Shared types, default sizes and the program address table for prog_sequencer.
// START_ADDR/END_ADDR hold the programs stored back-to-back in instruction memory.
package prog_seq_pkg;

  localparam int unsigned DEF_NUM_PROGS = 3;
  localparam int unsigned DEF_PC_W      = 10;
  localparam int unsigned DEF_CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FIN
  } seq_state_t;

  localparam logic [DEF_PC_W-1:0] START_ADDR [DEF_NUM_PROGS] = '{10'd0, 10'd169, 10'd366};
  localparam logic [DEF_PC_W-1:0] END_ADDR   [DEF_NUM_PROGS] = '{10'd168, 10'd365, 10'd590};

  // Index width never drops below one bit, even for a single-program table.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Control/status bundle between the top-level controller (master) and prog_sequencer (slave).
interface prog_sequencer_if
  import prog_seq_pkg::*;
#(
  parameter int unsigned NUM_PROGS = DEF_NUM_PROGS,
  parameter int unsigned PC_W      = DEF_PC_W,
  parameter int unsigned CNT_W     = DEF_CNT_W
);
  localparam int unsigned IDX_W = idx_width(NUM_PROGS);

  logic             start;
  logic [PC_W-1:0]  pc_in;
  logic             cpu_init;
  logic             pc_load;
  logic [PC_W-1:0]  pc_load_addr;
  logic             halt_req;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [IDX_W-1:0] prog_idx;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, pc_in,
    input  cpu_init, pc_load, pc_load_addr, halt_req, busy, done, aborted, prog_idx,
           cycle_count
  );

  modport slave (
    input  start, pc_in,
    output cpu_init, pc_load, pc_load_addr, halt_req, busy, done, aborted, prog_idx,
           cycle_count
  );

endinterface

// File: rtl/prog_table.sv
// Combinational start/end address lookup by program index.
// Indices beyond the stored table return address 0.
module prog_table
  import prog_seq_pkg::*;
#(
  parameter int unsigned  NUM_PROGS = DEF_NUM_PROGS,
  parameter int unsigned  PC_W      = DEF_PC_W,
  localparam int unsigned IDX_W     = idx_width(NUM_PROGS)
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic [PC_W-1:0]  o_start_addr,
  output logic [PC_W-1:0]  o_end_addr
);

  always_comb begin
    o_start_addr = '0;
    o_end_addr   = '0;
    for (int i = 0; i < int'(DEF_NUM_PROGS); i++) begin
      if ((i < int'(NUM_PROGS)) && (i_idx == IDX_W'(i))) begin
        o_start_addr = PC_W'(START_ADDR[i]);
        o_end_addr   = PC_W'(END_ADDR[i]);
      end
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Table-driven program sequencer: loads each program's entry PC, watches for its end
// address and halts the core. Optional RUN watchdog enabled by PROG_SEQ_WATCHDOG_EN.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned NUM_PROGS  = DEF_NUM_PROGS,
  parameter int unsigned PC_W       = DEF_PC_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned WDOG_LIMIT = 4095
) (
  input logic             CLK,
  input logic             init,
  prog_sequencer_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(NUM_PROGS);

  seq_state_t       r_state, w_state_d;
  logic [IDX_W-1:0] r_idx, w_idx_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d, w_cnt_inc;
  logic             r_halt, w_halt_d;
  logic             r_abort, w_abort_d;
  logic [PC_W-1:0]  w_start_addr, w_end_addr;
  logic             w_end_hit, w_wdog_hit;

  prog_table #(
    .NUM_PROGS (NUM_PROGS),
    .PC_W      (PC_W)
  ) u_table (
    .i_idx        (r_idx),
    .o_start_addr (w_start_addr),
    .o_end_addr   (w_end_addr)
  );

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_end_hit = (bus.pc_in == w_end_addr);

`ifdef PROG_SEQ_WATCHDOG_EN
  assign w_wdog_hit  = (w_cnt_inc >= CNT_W'(WDOG_LIMIT));
  assign bus.aborted = ~init & r_abort;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = ^{WDOG_LIMIT, r_abort};
  assign w_wdog_hit    = 1'b0;
  assign bus.aborted   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (init) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_halt  <= 1'b1;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_cnt   <= w_cnt_d;
      r_halt  <= w_halt_d;
      r_abort <= w_abort_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt;
    w_halt_d  = r_halt;
    w_abort_d = r_abort;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_d = LOAD;
        end
      end
      LOAD: begin
        w_cnt_d   = '0;
        w_halt_d  = 1'b0;
        w_abort_d = 1'b0;
        w_state_d = RUN;
      end
      RUN: begin
        w_cnt_d = w_cnt_inc;
        // An end match wins over a watchdog expiry in the same cycle.
        if (w_end_hit) begin
          w_state_d = FIN;
          w_halt_d  = 1'b1;
        end else if (w_wdog_hit) begin
          w_state_d = FIN;
          w_halt_d  = 1'b1;
          w_abort_d = 1'b1;
        end
      end
      FIN: begin
        w_halt_d  = 1'b1;
        w_idx_d   = (r_idx == IDX_W'(NUM_PROGS - 1)) ? '0 : r_idx + IDX_W'(1);
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  // init forces the core-holding outputs directly so they are valid from the first reset cycle.
  assign bus.cpu_init     = init | (r_state == LOAD);
  assign bus.pc_load      = ~init & (r_state == LOAD);
  assign bus.pc_load_addr = w_start_addr;
  assign bus.halt_req     = init | r_halt;
  assign bus.busy         = ~init & (r_state != IDLE);
  assign bus.done         = ~init & (r_state == FIN);
  assign bus.prog_idx     = r_idx;
  assign bus.cycle_count  = r_cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer with a simple incrementing PC model.
// Build with PROG_SEQ_WATCHDOG_EN to exercise the watchdog abort path.
module tb_prog_sequencer;

  localparam int unsigned NUM_PROGS  = 3;
  localparam int unsigned PC_W       = 10;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned WDOG_LIMIT = 50;

  logic            CLK = 1'b0;
  logic            init = 1'b1;
  logic            stall = 1'b0;
  logic [PC_W-1:0] r_pc = '0;

  int checks = 0;
  int errors = 0;

  prog_sequencer_if #(
    .NUM_PROGS (NUM_PROGS),
    .PC_W      (PC_W),
    .CNT_W     (CNT_W)
  ) bus ();

  prog_sequencer #(
    .NUM_PROGS  (NUM_PROGS),
    .PC_W       (PC_W),
    .CNT_W      (CNT_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) dut (
    .CLK  (CLK),
    .init (init),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // PC block model: load on strobe, otherwise count while the core is not halted.
  always @(posedge CLK) begin
    if (bus.pc_load) r_pc <= bus.pc_load_addr;
    else if (stall) r_pc <= 10'd5;
    else if (!bus.halt_req) r_pc <= r_pc + 10'd1;
  end
  assign bus.pc_in = r_pc;

  task automatic wait_done(input int limit, output bit seen, output logic [PC_W-1:0] prev_pc,
                           output int loads);
    seen    = 1'b0;
    prev_pc = '0;
    loads   = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.pc_load) loads++;
      prev_pc = bus.pc_in;
    end
  endtask

  task automatic test_reset();
    init      = 1'b1;
    bus.start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (bus.cpu_init !== 1'b1) begin errors++;
      $display("FAIL reset_cpu_init: got %0b expected 1", bus.cpu_init); end
    checks++; if (bus.halt_req !== 1'b1) begin errors++;
      $display("FAIL reset_halt_req: got %0b expected 1", bus.halt_req); end
    checks++; if (bus.prog_idx !== 2'd0) begin errors++;
      $display("FAIL reset_prog_idx: got %0d expected 0", bus.prog_idx); end
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.pc_load !== 1'b0) begin errors++;
      $display("FAIL reset_pc_load: got %0b expected 0", bus.pc_load); end
    init = 1'b0;
    @(negedge CLK);
    checks++; if (bus.cpu_init !== 1'b0) begin errors++;
      $display("FAIL idle_cpu_init: got %0b expected 0", bus.cpu_init); end
    checks++; if (bus.cycle_count !== 16'd0) begin errors++;
      $display("FAIL reset_cycle_count: got %0d expected 0", bus.cycle_count); end
    checks++; if (bus.aborted !== 1'b0 || bus.done !== 1'b0) begin errors++;
      $display("FAIL reset_abort_done: got %0b/%0b expected 0/0", bus.aborted, bus.done); end
  endtask

  task automatic test_program0();
    bit              seen;
    logic [PC_W-1:0] prev_pc;
    int              loads;
    bus.start = 1'b1;
    @(negedge CLK);
    checks++; if (bus.pc_load !== 1'b1 || bus.cpu_init !== 1'b1) begin errors++;
      $display("FAIL p0_load_strobe: got %0b/%0b expected 1/1", bus.pc_load, bus.cpu_init); end
    checks++; if (bus.pc_load_addr !== 10'd0) begin errors++;
      $display("FAIL p0_load_addr: got %0d expected 0", bus.pc_load_addr); end
    bus.start = 1'b0;
    wait_done(400, seen, prev_pc, loads);
    checks++; if (seen !== 1'b1) begin errors++;
      $display("FAIL p0_done_seen: got %0b expected 1", seen); end
    checks++; if (prev_pc !== 10'd168) begin errors++;
      $display("FAIL p0_end_pc: got %0d expected 168", prev_pc); end
    checks++; if (bus.cycle_count !== 16'd169) begin errors++;
      $display("FAIL p0_cycle_count: got %0d expected 169", bus.cycle_count); end
    checks++; if (bus.halt_req !== 1'b1) begin errors++;
      $display("FAIL p0_halt_req: got %0b expected 1", bus.halt_req); end
    @(negedge CLK);
    checks++; if (bus.prog_idx !== 2'd1) begin errors++;
      $display("FAIL p0_prog_idx: got %0d expected 1", bus.prog_idx); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++;
      $display("FAIL p0_idle: got busy %0b done %0b expected 0/0", bus.busy, bus.done); end
    checks++; if (bus.cycle_count !== 16'd169 || bus.halt_req !== 1'b1) begin errors++;
      $display("FAIL p0_hold: got cnt %0d halt %0b expected 169/1", bus.cycle_count,
               bus.halt_req); end
    checks++; if (bus.pc_load_addr !== 10'd169) begin errors++;
      $display("FAIL p0_next_addr: got %0d expected 169", bus.pc_load_addr); end
  endtask

  task automatic test_full_sequence();
    int              exp_load [3] = '{0, 169, 366};
    int              exp_end  [3] = '{168, 365, 590};
    int              exp_cnt  [3] = '{169, 197, 225};
    int              exp_idx  [3] = '{1, 2, 0};
    bit              seen;
    logic [PC_W-1:0] prev_pc;
    int              loads;
    init = 1'b1;
    @(negedge CLK);
    init = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      bus.start = 1'b1;
      @(negedge CLK);
      checks++; if (bus.pc_load !== 1'b1 || int'(bus.pc_load_addr) != exp_load[k]) begin
        errors++;
        $display("FAIL seq%0d_load: got strobe %0b addr %0d expected 1/%0d", k, bus.pc_load,
                 bus.pc_load_addr, exp_load[k]);
      end
      bus.start = 1'b0;
      wait_done(400, seen, prev_pc, loads);
      checks++; if (seen !== 1'b1 || int'(prev_pc) != exp_end[k]) begin errors++;
        $display("FAIL seq%0d_end: got seen %0b pc %0d expected 1/%0d", k, seen, prev_pc,
                 exp_end[k]); end
      checks++; if (int'(bus.cycle_count) != exp_cnt[k]) begin errors++;
        $display("FAIL seq%0d_cycles: got %0d expected %0d", k, bus.cycle_count, exp_cnt[k]); end
      @(negedge CLK);
      checks++; if (int'(bus.prog_idx) != exp_idx[k]) begin errors++;
        $display("FAIL seq%0d_prog_idx: got %0d expected %0d", k, bus.prog_idx, exp_idx[k]); end
    end
  endtask

  task automatic test_start_held();
    bit              seen;
    logic [PC_W-1:0] prev_pc;
    int              loads;
    bus.start = 1'b1;
    @(negedge CLK);
    checks++; if (bus.pc_load !== 1'b1 || bus.pc_load_addr !== 10'd0) begin errors++;
      $display("FAIL held_first_load: got %0b/%0d expected 1/0", bus.pc_load,
               bus.pc_load_addr); end
    wait_done(400, seen, prev_pc, loads);
    checks++; if (seen !== 1'b1 || loads != 0) begin errors++;
      $display("FAIL held_busy_loads: got seen %0b loads %0d expected 1/0", seen, loads); end
    @(negedge CLK);
    checks++; if (bus.pc_load !== 1'b0 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL held_idle_gap: got load %0b busy %0b expected 0/0", bus.pc_load,
               bus.busy); end
    @(negedge CLK);
    checks++; if (bus.pc_load !== 1'b1 || bus.pc_load_addr !== 10'd169) begin errors++;
      $display("FAIL held_second_load: got %0b/%0d expected 1/169", bus.pc_load,
               bus.pc_load_addr); end
    bus.start = 1'b0;
  endtask

  // Continues from the program-1 LOAD left by test_start_held.
  task automatic test_reset_mid_run();
    bit found = 1'b0;
    bit done_seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (bus.done) done_seen = 1'b1;
      if (bus.pc_in == 10'd300) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (found !== 1'b1 || done_seen !== 1'b0) begin errors++;
      $display("FAIL midrun_reach_300: got found %0b done %0b expected 1/0", found,
               done_seen); end
    init = 1'b1;
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0 || bus.prog_idx !== 2'd0) begin errors++;
      $display("FAIL midrun_state: got busy %0b idx %0d expected 0/0", bus.busy,
               bus.prog_idx); end
    checks++; if (bus.halt_req !== 1'b1 || bus.done !== 1'b0) begin errors++;
      $display("FAIL midrun_halt_done: got %0b/%0b expected 1/0", bus.halt_req, bus.done); end
    checks++; if (bus.cycle_count !== 16'd0) begin errors++;
      $display("FAIL midrun_count: got %0d expected 0", bus.cycle_count); end
    init      = 1'b0;
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (bus.done || bus.busy) done_seen = 1'b1;
    end
    checks++; if (done_seen !== 1'b0) begin errors++;
      $display("FAIL midrun_after: got activity %0b expected 0", done_seen); end
  endtask

  task automatic test_watchdog();
    bit              seen;
    logic [PC_W-1:0] prev_pc;
    int              loads;
    stall     = 1'b1;
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
`ifdef PROG_SEQ_WATCHDOG_EN
    wait_done(200, seen, prev_pc, loads);
    checks++; if (seen !== 1'b1 || bus.cycle_count !== 16'd50) begin errors++;
      $display("FAIL wdog_fin: got seen %0b cnt %0d expected 1/50", seen, bus.cycle_count); end
    checks++; if (bus.aborted !== 1'b1 || bus.halt_req !== 1'b1) begin errors++;
      $display("FAIL wdog_abort: got %0b/%0b expected 1/1", bus.aborted, bus.halt_req); end
    @(negedge CLK);
    checks++; if (bus.prog_idx !== 2'd1 || bus.aborted !== 1'b1) begin errors++;
      $display("FAIL wdog_after: got idx %0d abort %0b expected 1/1", bus.prog_idx,
               bus.aborted); end
`else
    wait_done(120, seen, prev_pc, loads);
    checks++; if (seen !== 1'b0 || bus.busy !== 1'b1) begin errors++;
      $display("FAIL nowdog_run: got done %0b busy %0b expected 0/1", seen, bus.busy); end
    checks++; if (bus.aborted !== 1'b0 || bus.cycle_count !== 16'd119) begin errors++;
      $display("FAIL nowdog_state: got abort %0b cnt %0d expected 0/119", bus.aborted,
               bus.cycle_count); end
`endif
    stall = 1'b0;
    init  = 1'b1;
    @(negedge CLK);
    init = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_program0();
    test_full_sequence();
    test_start_held();
    test_reset_mid_run();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
